// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: control/status bundle between the core and the PC/branch sequencer.
// Build option: BR_LINK_EN adds the LINK return-address signal (jump-and-link on BS=101).
// Signals:
//   EN     advance enable (0 = stall)
//   Z, N   ALU zero / negative flags
//   FW     latch Z/N into the registered flags
//   BR     current instruction is a branch
//   BS     branch condition select
//   OFF    signed PC-relative branch offset
//   HLT    halt request
//   GO     resume from halt
//   PC     current instruction address (registered)
//   MP     branch taken (combinational)
//   FLUSH  discard the instruction in decode (registered)
//   HALTED sequencer is halted (registered)
//   LINK   return address (BR_LINK_EN builds only)
// Modports: master = core side that drives requests, slave = the sequencer.
interface branch_sequencer_if #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned OFF_W = 8
);
    logic              EN;
    logic              Z;
    logic              N;
    logic              FW;
    logic              BR;
    logic [2:0]        BS;
    logic [OFF_W-1:0]  OFF;
    logic              HLT;
    logic              GO;
    logic [PC_W-1:0]   PC;
    logic              MP;
    logic              FLUSH;
    logic              HALTED;
`ifdef BR_LINK_EN
    logic [PC_W-1:0]   LINK;
`endif

    modport master (
        output EN, Z, N, FW, BR, BS, OFF, HLT, GO,
        input  PC, MP, FLUSH, HALTED
`ifdef BR_LINK_EN
        , input LINK
`endif
    );

    modport slave (
        input  EN, Z, N, FW, BR, BS, OFF, HLT, GO,
        output PC, MP, FLUSH, HALTED
`ifdef BR_LINK_EN
        , output LINK
`endif
    );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: owns the PC, the registered Z/N flags and branch-condition decode.
// Steps the PC, redirects on taken branches with a one-cycle flush bubble, and halts/resumes.
// Build option: BR_LINK_EN makes BS=101 an unconditional jump-and-link that loads LINK with PC+1.
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous active-high reset, overrides EN
//   bus  branch_sequencer_if.slave (EN, Z, N, FW, BR, BS, OFF, HLT, GO in;
//        PC, MP, FLUSH, HALTED[, LINK] out)
module branch_sequencer #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned OFF_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    branch_sequencer_if.slave   bus
);
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALT   = 2'd2
    } seqState_e;

    seqState_e          state;
    seqState_e          nextState;
    logic               zf;
    logic               nf;
    logic [PC_W-1:0]    pcQ;
    logic               flushQ;
    logic               haltedQ;
    logic               cond;
    logic               mp;
    logic [PC_W-1:0]    offExt;
    logic               isJal;

    // Signed cast widens with sign extension, including the OFF_W == PC_W case.
    assign offExt = PC_W'($signed(bus.OFF));
    assign isJal  = (bus.BS == 3'b101);

    // Branch condition from registered flags only; Z/N inputs never reach MP.
    always_comb begin
        cond = 1'b0;
        case (bus.BS)
            3'b000:  cond = zf;
            3'b001:  cond = ~zf;
            3'b010:  cond = ~nf;
            3'b011:  cond = nf;
            3'b100:  cond = 1'b1;
`ifdef BR_LINK_EN
            3'b101:  cond = 1'b1;
`endif
            default: cond = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else if (bus.EN) begin
            state <= nextState;
        end
    end

    // Next-state logic; halt request wins over a taken branch in RUN.
    always_comb begin
        nextState = state;
        case (state)
            RUN: begin
                if (bus.HLT) begin
                    nextState = HALT;
                end else if (mp) begin
                    nextState = BUBBLE;
                end
            end
            BUBBLE:  nextState = RUN;
            HALT: begin
                if (bus.GO) begin
                    nextState = RUN;
                end
            end
            default: nextState = RUN;
        endcase
    end

    // Output logic: taken-branch decision, suppressed outside RUN and under a halt request.
    always_comb begin
        mp = 1'b0;
        if ((state == RUN) && !bus.HLT) begin
            mp = bus.BR & cond;
        end
    end

    // PC, flags and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pcQ     <= '0;
            zf      <= 1'b0;
            nf      <= 1'b0;
            flushQ  <= 1'b0;
            haltedQ <= 1'b0;
        end else if (bus.EN) begin
            if ((state == RUN) && !bus.HLT) begin
                pcQ <= mp ? (pcQ + offExt) : (pcQ + PC_W'(1));
            end
            // Flags freeze while halted; a same-cycle branch already used the old values.
            if (bus.FW && (state != HALT)) begin
                zf <= bus.Z;
                nf <= bus.N;
            end
            flushQ  <= (nextState == BUBBLE);
            haltedQ <= (nextState == HALT);
        end
    end

`ifdef BR_LINK_EN
    logic [PC_W-1:0] linkQ;

    // Return address captured on the jump-and-link edge only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            linkQ <= '0;
        end else if (bus.EN && mp && isJal) begin
            linkQ <= pcQ + PC_W'(1);
        end
    end

    assign bus.LINK = linkQ;
`else
    logic unusedJal;
    assign unusedJal = isJal;
`endif

    assign bus.PC     = pcQ;
    assign bus.MP     = mp;
    assign bus.FLUSH  = flushQ;
    assign bus.HALTED = haltedQ;
endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Program-counter and branch sequencer for the CPU. It owns the PC register, the registered Z/N status flags, and the branch-condition decode (BS select). It steps the PC sequentially, redirects it on taken branches with a one-cycle flush bubble, and supports halt/resume. It sits between the ALU flag outputs and the instruction-memory address input.

## Interface
- PC_W, 8: PC width in bits; instruction-word addressed.
- OFF_W, 8: branch offset width, signed two's complement, OFF_W ≤ PC_W.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  advance enable; 0 = stall, all state holds.
- Z  in  1  ALU zero flag.
- N  in  1  ALU negative flag.
- FW  in  1  flag write; latch Z/N into ZF/NF.
- BR  in  1  current instruction is a branch; BS is valid.
- BS  in  3  branch select: 000 ZF, 001 !ZF, 010 !NF, 011 NF, 100 always, 101 JAL (see Configuration), 110/111 never.
- OFF  in  OFF_W  signed PC-relative branch offset.
- HLT  in  1  halt request.
- GO  in  1  resume from HALT.
- PC  out  PC_W  current instruction address (registered).
- MP  out  1  branch taken (combinational).
- FLUSH  out  1  discard the instruction in decode (registered).
- HALTED  out  1  high while in HALT.
- LINK  out  PC_W  return address (only with BR_LINK_EN).

## Operation
- States:
  - RUN: normal stepping.
  - BUBBLE: one cycle after a taken branch.
  - HALT: stopped until GO.
- Flags: ZF/NF are registered. When FW=1 and EN=1, they load Z/N at the clock edge.
- Condition source: branches always evaluate the registered ZF/NF. If FW and BR are both high in the same cycle, the branch uses the old flags.
- MP = BR & cond(BS, ZF, NF) & (state==RUN) & !HLT. MP is forced to 0 in BUBBLE and in HALT.
- RUN, EN=1, the first matching rule applies:
  1. HLT=1: go to HALT; PC holds; any branch is ignored.
  2. MP=1: PC <= PC + sign_extend(OFF); go to BUBBLE.
  3. Otherwise: PC <= PC + 1.
- BUBBLE, EN=1: FLUSH=1; PC holds at the target; go to RUN. A taken branch therefore costs 2 cycles.
- HALT: PC and flags hold; HALTED=1. GO=1 with EN=1 returns to RUN. The PC still addresses the instruction after the halt point.
- EN=0 in any state: no state, PC, flag, FLUSH or LINK change. Outputs hold their values.
- Arithmetic: PC + 1 and PC + offset are both modulo 2^PC_W. 2^PC_W−1 + 1 wraps to 0. A negative offset that goes below 0 wraps upward.
- RST has priority over everything, including EN=0. Mid-branch or mid-halt state is discarded.

## Timing
- Reset values: PC=0, ZF=0, NF=0, state=RUN, FLUSH=0, HALTED=0, LINK=0.
- MP is valid in the same cycle as BR/BS, with combinational depth from registered flags only. It does not depend on the Z/N inputs.
- Flag latency: the flags written by FW at edge k are visible to a branch in cycle k+1.
- PC redirect: a taken branch in cycle k gives PC=target from cycle k+1. FLUSH is high during cycle k+1 only. Sequential stepping resumes at edge k+2.
- HALTED rises the cycle after HLT is accepted and falls the cycle after GO is accepted.

## Configuration
- BR_LINK_EN defined:
  - BS=101 is an unconditional jump-and-link. It branches like 100.
  - LINK loads PC+1 (wrapped) on the same edge.
  - LINK holds otherwise and resets to 0.
- BR_LINK_EN undefined:
  - BS=101 is never taken.
  - The LINK port and register are absent.

## Test plan
- Reset then 4 cycles with EN=1, BR=0 → PC 0,1,2,3,4; FLUSH=0; MP=0.
- FW=1 with Z=1 at cycle 0, then BR=1, BS=000, OFF=+5 at PC=1 → MP=1, next PC=6, FLUSH=1 for one cycle, then PC=7.
- FW=1 with Z=0 and BR=1, BS=000 in the same cycle, with ZF previously 1 → branch taken on the old flag; ZF=0 afterwards.
- PC=0xFE, BS=100, OFF=+3 (PC_W=8) → PC=0x01. Then at PC=0x01, BS=011 with NF=0 → not taken, PC=0x02.
- HLT=1 and a taken branch in the same cycle at PC=9 → HALTED=1, PC stays 9. EN=0 with GO=1 → still halted. EN=1 with GO=1 → RUN, PC steps to 10.
- BR_LINK_EN build: BS=101 at PC=0x20, OFF=−16 → PC=0x10, LINK=0x21. Without the macro: same stimulus → not taken, PC=0x21.
